// File: rtl/aemb_prefetch_queue.sv
// Instruction prefetch queue for the AEMB core: a WISHBONE classic fetch master
// that fills a DEPTH-entry FIFO of {pc, instruction} pairs for the decode stage.
module aemb_prefetch_queue #(
  parameter int             ISIZ     = 32,
  parameter int             DEPTH    = 4,
  parameter int             DLOG     = 2,
  parameter logic [ISIZ-1:0] RESET_PC = '0
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  output logic [ISIZ-1:0] iwb_adr_o,
  output logic            iwb_stb_o,
  input  logic [31:0]     iwb_dat_i,
  input  logic            iwb_ack_i,
  output logic            ins_vld_o,
  output logic [31:0]     ins_dat_o,
  output logic [ISIZ-1:0] ins_pc_o,
  input  logic            ins_rdy_i,
  input  logic            bra_i,
  input  logic [ISIZ-1:0] bra_adr_i,
  output logic [DLOG:0]   q_cnt_o
);

  localparam logic [DLOG:0]   FULL_CNT = (DLOG+1)'(DEPTH);
  localparam logic [ISIZ-1:0] WORD_INC = ISIZ'(4);

  logic            stb_q, stb_d;
  logic [ISIZ-1:0] adr_q, adr_d;
  logic [ISIZ-1:0] tgt_q, tgt_d;
  logic            discard_q, discard_d;
  logic [DLOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DLOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DLOG:0]   cnt_q, cnt_d;

  logic [31:0]     dat_mem [DEPTH];
  logic [ISIZ-1:0] pc_mem  [DEPTH];

  logic            ack_ok;
  logic            push;
  logic            pop;
  logic            head_vld;
  logic [ISIZ-1:0] bra_tgt;
  logic [1:0]      bra_lsb_unused;

  assign bra_tgt        = {bra_adr_i[ISIZ-1:2], 2'b00};
  assign bra_lsb_unused = bra_adr_i[1:0];
  assign head_vld       = (cnt_q != '0);

  always_comb begin
    ack_ok    = stb_q & iwb_ack_i;
    push      = ack_ok & ~discard_q & ~bra_i;
    pop       = head_vld & ins_rdy_i & ~bra_i;

    stb_d     = stb_q;
    adr_d     = adr_q;
    tgt_d     = tgt_q;
    discard_d = discard_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;

    if (bra_i) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      // An unacked request must keep its address on the bus; remember the target.
      if (!stb_q || iwb_ack_i) begin
        adr_d     = bra_tgt;
        discard_d = 1'b0;
        stb_d     = 1'b1;
      end else begin
        tgt_d     = bra_tgt;
        discard_d = 1'b1;
      end
    end else begin
      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // A new request is allowed only if its data will have a free slot.
      if (ack_ok) begin
        adr_d     = discard_q ? tgt_q : (adr_q + WORD_INC);
        discard_d = 1'b0;
        stb_d     = (cnt_d < FULL_CNT);
      end else if (!stb_q) begin
        stb_d     = (cnt_d < FULL_CNT);
      end
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      stb_q     <= 1'b0;
      adr_q     <= RESET_PC;
      tgt_q     <= RESET_PC;
      discard_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      stb_q     <= stb_d;
      adr_q     <= adr_d;
      tgt_q     <= tgt_d;
      discard_q <= discard_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      dat_mem[wr_ptr_q] <= iwb_dat_i;
      pc_mem[wr_ptr_q]  <= adr_q;
    end
  end

  // Head is masked while empty so stale storage never leaks out after reset.
  assign iwb_adr_o = adr_q;
  assign iwb_stb_o = stb_q;
  assign ins_vld_o = head_vld;
  assign ins_dat_o = head_vld ? dat_mem[rd_ptr_q] : '0;
  assign ins_pc_o  = head_vld ? pc_mem[rd_ptr_q]  : '0;
  assign q_cnt_o   = cnt_q;

endmodule

// File: tb/tb_aemb_prefetch_queue.sv
// Directed self-checking bench for aemb_prefetch_queue: fill, steady state,
// branch flush/discard, address wrap on a narrow instance and mid-request reset.
module tb_aemb_prefetch_queue;

  logic        clock;
  logic        reset;
  logic [31:0] iwbAdr;
  logic        iwbStb;
  logic [31:0] iwbDat;
  logic        iwbAck;
  logic        insVld;
  logic [31:0] insDat;
  logic [31:0] insPc;
  logic        insRdy;
  logic        bra;
  logic [31:0] braAdr;
  logic [2:0]  qCnt;

  logic        reset8;
  logic [7:0]  iwbAdr8;
  logic        iwbStb8;
  logic [31:0] iwbDat8;
  logic        iwbAck8;
  logic        insVld8;
  logic [31:0] insDat8;
  logic [7:0]  insPc8;
  logic        insRdy8;
  logic        bra8;
  logic [7:0]  braAdr8;
  logic [2:0]  qCnt8;

  int checks;
  int passes;

  // Memory model: returned data encodes the requested address.
  assign iwbDat  = {16'hC0DE, iwbAdr[15:0]};
  assign iwbDat8 = {24'h5A5A5A, iwbAdr8};

  aemb_prefetch_queue dut (
    .sys_clk_i(clock), .sys_rst_i(reset),
    .iwb_adr_o(iwbAdr), .iwb_stb_o(iwbStb), .iwb_dat_i(iwbDat), .iwb_ack_i(iwbAck),
    .ins_vld_o(insVld), .ins_dat_o(insDat), .ins_pc_o(insPc), .ins_rdy_i(insRdy),
    .bra_i(bra), .bra_adr_i(braAdr), .q_cnt_o(qCnt)
  );

  aemb_prefetch_queue #(.ISIZ(8), .DEPTH(4), .DLOG(2), .RESET_PC(8'hF8)) dut8 (
    .sys_clk_i(clock), .sys_rst_i(reset8),
    .iwb_adr_o(iwbAdr8), .iwb_stb_o(iwbStb8), .iwb_dat_i(iwbDat8), .iwb_ack_i(iwbAck8),
    .ins_vld_o(insVld8), .ins_dat_o(insDat8), .ins_pc_o(insPc8), .ins_rdy_i(insRdy8),
    .bra_i(bra8), .bra_adr_i(braAdr8), .q_cnt_o(qCnt8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic ack, input logic rdy, input logic br,
                               input logic [31:0] brAdr);
    iwbAck = ack;
    insRdy = rdy;
    bra    = br;
    braAdr = brAdr;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  initial begin
    checks  = 0;
    passes  = 0;
    reset   = 1'b1;
    reset8  = 1'b1;
    iwbAck8 = 1'b0;
    insRdy8 = 1'b0;
    bra8    = 1'b0;
    braAdr8 = 8'h00;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #3;
    checkOutput("rst_stb", {31'b0, iwbStb}, 32'h0);
    checkOutput("rst_vld", {31'b0, insVld}, 32'h0);
    checkOutput("rst_cnt", {29'b0, qCnt}, 32'h0);
    checkOutput("rst_adr", iwbAdr, 32'h0);
    tick();
    reset = 1'b0;

    // Fill from reset with ack every cycle and no consumer
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("fill_stb", {31'b0, iwbStb}, 32'h1);
      checkOutput("fill_adr", iwbAdr, 32'(i * 4 + 4) - 32'h4);
      checkOutput("fill_cnt", {29'b0, qCnt}, 32'(i));
    end
    tick();
    checkOutput("full_cnt", {29'b0, qCnt}, 32'h4);
    checkOutput("full_stb", {31'b0, iwbStb}, 32'h0);
    checkOutput("full_pc", insPc, 32'h0);
    checkOutput("full_dat", insDat, 32'hC0DE0000);

    // One pop from full reopens fetch at 0x10
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("pop_cnt", {29'b0, qCnt}, 32'h3);
    checkOutput("pop_stb", {31'b0, iwbStb}, 32'h1);
    checkOutput("pop_adr", iwbAdr, 32'h10);
    checkOutput("pop_pc", insPc, 32'h4);

    // Steady state: push and pop every cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("ss_cnt", {29'b0, qCnt}, 32'h3);
      checkOutput("ss_pc", insPc, 32'h8 + 32'(i * 4));
      checkOutput("ss_adr", iwbAdr, 32'h14 + 32'(i * 4));
    end

    // Branch while a request is stalled at 0x8
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("stall_adr", iwbAdr, 32'h8);
    checkOutput("stall_cnt", {29'b0, qCnt}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h103);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("disc_adr", iwbAdr, 32'h8);
    checkOutput("disc_stb", {31'b0, iwbStb}, 32'h1);
    tick();
    checkOutput("disc_hold", iwbAdr, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("drop_cnt", {29'b0, qCnt}, 32'h0);
    checkOutput("drop_adr", iwbAdr, 32'h100);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("tgt_vld", {31'b0, insVld}, 32'h1);
    checkOutput("tgt_pc", insPc, 32'h100);
    checkOutput("tgt_dat", insDat, 32'hC0DE0100);

    // Branch coinciding with an ack while two entries are held
    tick();
    checkOutput("two_cnt", {29'b0, qCnt}, 32'h2);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("bra_ack_cnt", {29'b0, qCnt}, 32'h0);
    checkOutput("bra_ack_adr", iwbAdr, 32'h200);
    checkOutput("bra_ack_stb", {31'b0, iwbStb}, 32'h1);
    tick();
    checkOutput("bra_ack_pc", insPc, 32'h200);
    checkOutput("bra_ack_n", {29'b0, qCnt}, 32'h1);

    // Asynchronous reset with three entries queued and a request in flight
    tick();
    tick();
    checkOutput("pre_rst_cnt", {29'b0, qCnt}, 32'h3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_vld", {31'b0, insVld}, 32'h0);
    checkOutput("mid_rst_stb", {31'b0, iwbStb}, 32'h0);
    checkOutput("mid_rst_cnt", {29'b0, qCnt}, 32'h0);
    checkOutput("mid_rst_adr", iwbAdr, 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("restart_stb", {31'b0, iwbStb}, 32'h1);
    checkOutput("restart_adr", iwbAdr, 32'h0);
    checkOutput("restart_cnt", {29'b0, qCnt}, 32'h0);
    tick();
    checkOutput("restart_pc", insPc, 32'h0);
    checkOutput("restart_n", {29'b0, qCnt}, 32'h1);

    // Narrow address bus wraps from 0xFC to 0x00
    iwbAck8 = 1'b1;
    reset8  = 1'b0;
    tick();
    checkOutput("w8_adr0", {24'b0, iwbAdr8}, 32'hF8);
    tick();
    checkOutput("w8_adr1", {24'b0, iwbAdr8}, 32'hFC);
    tick();
    checkOutput("w8_adr2", {24'b0, iwbAdr8}, 32'h00);
    tick();
    iwbAck8 = 1'b0;
    insRdy8 = 1'b1;
    checkOutput("w8_cnt", {29'b0, qCnt8}, 32'h3);
    checkOutput("w8_pc0", {24'b0, insPc8}, 32'hF8);
    tick();
    checkOutput("w8_pc1", {24'b0, insPc8}, 32'hFC);
    tick();
    checkOutput("w8_pc2", {24'b0, insPc8}, 32'h00);
    checkOutput("w8_dat2", insDat8, 32'h5A5A5A00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aemb_prefetch_queue.md
Name: aemb_prefetch_queue

Overview:
Parametrised instruction prefetch unit for the AEMB core. It is the successor to the single-word fetch stage and supports configurable address width and queue depth. It runs as a WISHBONE classic master on the instruction bus and keeps up to DEPTH prefetched words, each tagged with its PC, in a FIFO. The decode stage consumes the words through a valid/ready handshake, and a branch flushes the queue and redirects fetch.

Parameters:
ISIZ, 32, instruction address width in bits (>= 3)
DEPTH, 4, number of queue entries; power of two, >= 2
DLOG, 2, log2(DEPTH)
RESET_PC, 0, fetch address after reset; bits [1:0] must be 0

Ports:
sys_clk_i  input  1  core clock, rising edge
sys_rst_i  input  1  reset; asynchronous, active-high
iwb_adr_o  output  ISIZ  WISHBONE instruction address, word aligned
iwb_stb_o  output  1  WISHBONE strobe (also serves as cyc)
iwb_dat_i  input  32  WISHBONE read data
iwb_ack_i  input  1  WISHBONE acknowledge
ins_vld_o  output  1  head entry valid
ins_dat_o  output  32  head instruction word
ins_pc_o  output  ISIZ  PC of head instruction
ins_rdy_i  input  1  consumer accepts head this cycle
bra_i  input  1  branch taken: flush queue and redirect fetch
bra_adr_i  input  ISIZ  branch target; bits [1:0] are ignored (forced 0)
q_cnt_o  output  DLOG+1  number of valid entries, 0..DEPTH

Behaviour:
- Reset values (sys_rst_i high, asynchronous):
  - iwb_stb_o=0, iwb_adr_o=RESET_PC.
  - ins_vld_o=0, q_cnt_o=0, read/write pointers=0.
  - discard flag=0, ins_dat_o/ins_pc_o=0.
- Bus protocol:
  - At most one outstanding request.
  - iwb_stb_o rises on a clock edge when the bus is idle and (q_cnt + 1 pending slot) <= DEPTH, i.e. q_cnt < DEPTH.
  - Once raised, iwb_stb_o and iwb_adr_o hold until the cycle in which iwb_ack_i=1 is sampled.
  - If issue is still allowed at that ack, stb stays high and the address advances (back-to-back fetch); otherwise stb drops.
- Push: on ack with the discard flag clear and no bra_i, write {iwb_adr_o, iwb_dat_i} at wr_ptr. Then wr_ptr+1 mod DEPTH and fetch address += 4 (wraps modulo 2^ISIZ).
- Pop: when ins_vld_o & ins_rdy_i, rd_ptr+1 mod DEPTH.
- Simultaneous push and pop: q_cnt unchanged.
- Pop while empty: ignored.
- Head outputs:
  - ins_vld_o = (q_cnt != 0).
  - ins_dat_o/ins_pc_o come combinationally from the entry at rd_ptr.
- Full: at q_cnt == DEPTH no new request is issued. A request already in flight cannot exist at full, because issue requires q_cnt < DEPTH counting the pending slot.
- Latency: ack sampled at edge N gives ins_vld_o=1 after edge N (same cycle the count updates). First stb is high on the first edge after reset release.
- Branch (bra_i=1 at an edge; highest priority):
  - q_cnt=0, rd_ptr=wr_ptr=0, fetch address = {bra_adr_i[ISIZ-1:2], 2'b00}.
  - Any pop or push in that cycle is cancelled.
  - If no request is outstanding, or iwb_ack_i=1 in the same cycle: the returning data is dropped and stb is high next cycle at the branch target.
  - If a request is outstanding without ack: stb and the old address hold (WISHBONE rule) and the discard flag is set. When that ack arrives, the data is dropped, the flag clears, and the next request goes to the target.
  - A further bra_i while discard is set only updates the target.
- Reset mid-transfer: everything returns to reset values immediately. A late ack after release with stb=0 is ignored.
- Storage: plain register array of DEPTH x (32+ISIZ), not reset-sensitive except for the pointers and count.

Test Plan:
1. Reset release, RESET_PC=0, ack every cycle, ins_rdy_i=0 -> requests to 0x0,0x4,0x8,0xC. q_cnt_o reaches 4 and iwb_stb_o drops. ins_pc_o=0x0 with ins_dat_o equal to the first data word.
2. Full queue, then ins_rdy_i=1 for one cycle -> q_cnt 4->3, stb reasserts at 0x10. Steady state with ack and ready every cycle keeps q_cnt constant and PCs strictly +4.
3. Stb held at 0x8 with ack withheld 3 cycles, bra_i=1 with bra_adr_i=0x103 -> iwb_adr_o stays 0x8 until ack, that data is dropped (q_cnt stays 0), next request is 0x100, and the first valid ins_pc_o is 0x100.
4. bra_i and iwb_ack_i in the same cycle with the queue holding 2 entries -> q_cnt=0, acked data discarded, next-cycle iwb_adr_o = target.
5. ISIZ=8, fetch from 0xF8 -> addresses 0xF8, 0xFC, 0x00; entries carry PCs 0xF8, 0xFC, 0x00.
6. sys_rst_i pulsed mid-request with 3 entries queued -> outputs immediately show reset values (ins_vld_o=0, stb=0). After release, fetch restarts at RESET_PC.
